regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with per-register scoreboard
//  (pending-write) tracking and optional write-to-read bypass. Sits in the
//  decode/writeback boundary of the FyraVortex pipeline:
//  - issue reserves destinations;
//  - writeback ports retire them;
//  - decode reads operands plus a "not yet valid" flag per read port.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  NUM_REGS    32  architectural registers (>=2); register 0 hardwired to zero
//  NUM_RD       2  read ports (>=1)
//  NUM_WR       2  write ports (>=1)
//  BYPASS       1  1: same-cycle write data forwarded to reads; 0: read returns stored value
//  ADDR_W      $clog2(NUM_REGS)  localparam, not overridable
// PORTS
//  clk        in   1                    clock, all state updates on posedge
//  rst        in   1                    asynchronous, active-high reset
//  rdAddr     in   NUM_RD x ADDR_W      read addresses
//  rdData     out  NUM_RD x DATA_WIDTH  read data (combinational)
//  rdPending  out  NUM_RD               1 = operand has an outstanding reservation
//  wrEn       in   NUM_WR               write enables
//  wrAddr     in   NUM_WR x ADDR_W      write addresses
//  wrData     in   NUM_WR x DATA_WIDTH  write data
//  resvEn     in   1                    reserve (mark pending) destination at issue
//  resvAddr   in   ADDR_W               destination being reserved
//  anyPending out  1                    OR of all busy bits (pipeline drain indicator)
// BEHAVIOUR
//  Reset:
//  - rst high asynchronously clears all registers to 0 and all busy bits to 0.
//  - Outputs then read 0 / not pending; anyPending=0.
//  - Reset mid-operation discards all in-flight writes and reservations.
//  Writes:
//  - On posedge, each port with wrEn=1, wrAddr!=0 and wrAddr<NUM_REGS updates the register.
//  - Several ports to the same address: highest port index wins.
//  - Writes to reg 0 or out-of-range addresses are dropped.
//  Scoreboard:
//  - Valid write clears the busy bit of wrAddr.
//  - resvEn with resvAddr!=0 sets busy[resvAddr].
//  - Same-cycle reserve and write to the same register: reserve wins (busy ends 1,
//    data still written).
//  - busy[0] is constant 0.
//  - Reserving an already-busy register keeps it busy (no counting).
//  Reads (0-cycle latency, purely combinational from state and write ports):
//  - rdAddr==0 or >=NUM_REGS: rdData=0, rdPending=0.
//  - BYPASS=1 and any valid write port matches rdAddr this cycle: rdData = that
//    port's wrData (highest index on multi-match), rdPending=0.
//  - Otherwise rdData=reg[rdAddr], rdPending=busy[rdAddr].
//  - Same-cycle resvEn does not affect rdPending until the next cycle.
//  - BYPASS=0: reads never see same-cycle writes; rdPending reflects busy only.
//  anyPending: registered view, i.e. OR over the busy array.
// STRUCTURE
//  - Package regfile_pkg: typedefs reg_addr_t/reg_data_t (parametrised via
//    localparams), constant REG_ZERO='0.
//  - One sub-module regfile_rd_port: single read port.
//    - Inputs: addr, register array view, busy vector, write-port bundle.
//    - Outputs: data, pending.
//    - Instantiated NUM_RD times in a generate loop.
//  - Top holds the storage array, busy vector, write-priority logic and reset.
// TESTING (DATA_WIDTH=32, NUM_REGS=32, NUM_RD=2, NUM_WR=2, BYPASS=1 unless noted)
//  1 Reset:
//    - Stimulus: write x5=0xAA, assert rst asynchronously between edges.
//    - Response: rdData for x5 reads 0 immediately, anyPending=0.
//  2 Priority:
//    - Stimulus: wr0 x7=0x11, wr1 x7=0x22 same edge.
//    - Response: next cycle read x7=0x22; a write to x0=0xFF still reads 0.
//  3 Bypass:
//    - Stimulus: wr0 x3=0x1234 while rdAddr[0]=3.
//    - Response: same cycle rdData[0]=0x1234.
//    - With BYPASS=0: old value 0, then 0x1234 next cycle.
//  4 Scoreboard:
//    - Stimulus: resv x9; next cycle rdPending for x9=1, anyPending=1;
//      then write x9=0x5 with rdAddr=9.
//    - Response: rdPending=0 and rdData=5 same cycle; anyPending=0 after the edge.
//  5 Reserve/write collision:
//    - Stimulus: resv x4 and wr1 x4=0x77 same edge.
//    - Response: x4 reads 0x77 with rdPending=1.
//  6 Range (NUM_REGS=24):
//    - Stimulus: write addr 30.
//    - Response: dropped; read addr 30 returns 0, pending=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_REGS_DEF   = 32;
    localparam int ADDR_W_DEF     = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0]     reg_addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

    localparam reg_data_t REG_ZERO = '0;

    // Register 0 is hardwired to zero and addresses past the array do not exist,
    // so neither may be written, reserved or read as real state.
    function automatic logic addrValid(input int unsigned addr, input int unsigned numRegs);
        return (addr != 0) && (addr < numRegs);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and reservation bundle between the pipeline and the register file.
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][ADDR_W-1:0]     rdAddr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdData;
    logic [NUM_RD-1:0]                 rdPending;
    logic [NUM_WR-1:0]                 wrEn;
    logic [NUM_WR-1:0][ADDR_W-1:0]     wrAddr;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0] wrData;
    logic                              resvEn;
    logic [ADDR_W-1:0]                 resvAddr;
    logic                              anyPending;

    modport master (
        output rdAddr, wrEn, wrAddr, wrData, resvEn, resvAddr,
        input  rdData, rdPending, anyPending
    );

    modport slave (
        input  rdAddr, wrEn, wrAddr, wrData, resvEn, resvAddr,
        output rdData, rdPending, anyPending
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port with optional same-cycle forwarding from the write ports.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_WR     = 2,
    parameter bit BYPASS     = 1'b1,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0]                   addr_i,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_i,
    input  logic [NUM_REGS-1:0]                 busy_i,
    input  logic [NUM_WR-1:0]                   wrValid_i,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]       wrAddr_i,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wrData_i,
    output logic [DATA_WIDTH-1:0]               data_o,
    output logic                                pending_o
);

    // Stored value first; later write ports override earlier ones so the highest index wins.
    always_comb begin
        data_o    = '0;
        pending_o = 1'b0;
        if (addrValid(32'(addr_i), NUM_REGS)) begin
            data_o    = regs_i[addr_i];
            pending_o = busy_i[addr_i];
            if (BYPASS) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wrValid_i[w] && (wrAddr_i[w] == addr_i)) begin
                        data_o    = wrData_i[w];
                        pending_o = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard for issue/writeback tracking.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter bit BYPASS     = 1'b1,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 busy_q, busy_d;
    logic [NUM_WR-1:0]                   wrValid;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rdData;
    logic [NUM_RD-1:0]                   rdPending;

    // A write port only counts when enabled and aimed at a real, non-zero register.
    always_comb begin
        wrValid = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wrValid[w] = bus.wrEn[w] && addrValid(32'(bus.wrAddr[w]), NUM_REGS);
        end
    end

    // Writes retire in port order (highest wins); a same-cycle reservation is applied last so it wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wrValid[w]) begin
                regs_d[bus.wrAddr[w]] = bus.wrData[w];
                busy_d[bus.wrAddr[w]] = 1'b0;
            end
        end
        if (bus.resvEn && addrValid(32'(bus.resvAddr), NUM_REGS)) begin
            busy_d[bus.resvAddr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // Storage and scoreboard; reset throws away every value and outstanding reservation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    genvar r;
    generate
        for (r = 0; r < NUM_RD; r++) begin : gRd
            regfile_rd_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .NUM_REGS   (NUM_REGS),
                .NUM_WR     (NUM_WR),
                .BYPASS     (BYPASS)
            ) uRdPort (
                .addr_i    (bus.rdAddr[r]),
                .regs_i    (regs_q),
                .busy_i    (busy_q),
                .wrValid_i (wrValid),
                .wrAddr_i  (bus.wrAddr),
                .wrData_i  (bus.wrData),
                .data_o    (rdData[r]),
                .pending_o (rdPending[r])
            );
        end
    endgenerate

    assign bus.rdData     = rdData;
    assign bus.rdPending  = rdPending;
    assign bus.anyPending = |busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks of regfile_mp: default build, a no-bypass build and a 24-register build.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    regfile_mp_if                  busA ();
    regfile_mp_if                  busB ();
    regfile_mp_if #(.NUM_REGS(24)) busC ();

    regfile_mp dutA (.clk(clk), .rst(rst), .bus(busA));
    regfile_mp #(.BYPASS(1'b0)) dutB (.clk(clk), .rst(rst), .bus(busB));
    regfile_mp #(.NUM_REGS(24)) dutC (.clk(clk), .rst(rst), .bus(busC));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input reg_data_t observed, input reg_data_t expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [4:0] a0, input reg_data_t d0,
                                 input logic [4:0] a1, input reg_data_t d1,
                                 input logic rEn, input logic [4:0] rAddr);
        busA.wrEn      = en;
        busA.wrAddr[0] = a0;
        busA.wrData[0] = d0;
        busA.wrAddr[1] = a1;
        busA.wrData[1] = d1;
        busA.resvEn    = rEn;
        busA.resvAddr  = rAddr;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        busA.rdAddr = '0; busA.wrEn = '0; busA.wrAddr = '0; busA.wrData = '0;
        busA.resvEn = 1'b0; busA.resvAddr = '0;
        busB.rdAddr = '0; busB.wrEn = '0; busB.wrAddr = '0; busB.wrData = '0;
        busB.resvEn = 1'b0; busB.resvAddr = '0;
        busC.rdAddr = '0; busC.wrEn = '0; busC.wrAddr = '0; busC.wrData = '0;
        busC.resvEn = 1'b0; busC.resvAddr = '0;
        #12;
        rst = 1'b0;
        busA.rdAddr[0] = 5'd5;
        #1;
        checkOutput("reset_rd", busA.rdData[0], 32'h0);
        checkOutput("reset_any", 32'(busA.anyPending), 32'h0);

        // Write x5 and reserve x6, then reset asynchronously between edges.
        applyStimulus(2'b01, 5'd5, 32'hAA, 5'd0, 32'h0, 1'b1, 5'd6);
        step;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("pre_rst_x5", busA.rdData[0], 32'hAA);
        checkOutput("pre_rst_any", 32'(busA.anyPending), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_x5", busA.rdData[0], 32'h0);
        checkOutput("async_rst_any", 32'(busA.anyPending), 32'h0);
        rst = 1'b0;
        step;

        // Two ports writing x7 on the same edge.
        applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0);
        busA.rdAddr[1] = 5'd7;
        #1;
        checkOutput("prio_bypass", busA.rdData[1], 32'h22);
        step;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        busA.rdAddr[0] = 5'd7;
        #1;
        checkOutput("prio_stored", busA.rdData[0], 32'h22);
        applyStimulus(2'b01, 5'd0, 32'hFF, 5'd0, 32'h0, 1'b0, 5'd0);
        busA.rdAddr[0] = 5'd0;
        #1;
        checkOutput("x0_same_cycle", busA.rdData[0], 32'h0);
        step;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("x0_stored", busA.rdData[0], 32'h0);
        checkOutput("x0_pending", 32'(busA.rdPending[0]), 32'h0);

        // Forwarding versus no forwarding.
        applyStimulus(2'b01, 5'd3, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0);
        busA.rdAddr[0] = 5'd3;
        busB.wrEn = 2'b01; busB.wrAddr[0] = 5'd3; busB.wrData[0] = 32'h1234;
        busB.rdAddr[0] = 5'd3;
        #1;
        checkOutput("bypass_on", busA.rdData[0], 32'h1234);
        checkOutput("bypass_off_old", busB.rdData[0], 32'h0);
        step;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        busB.wrEn = 2'b00;
        #1;
        checkOutput("bypass_off_new", busB.rdData[0], 32'h1234);
        checkOutput("bypass_on_stored", busA.rdData[0], 32'h1234);

        // Reserve x9, then retire it with a write.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
        busA.rdAddr[1] = 5'd9;
        #1;
        checkOutput("resv_same_cycle", 32'(busA.rdPending[1]), 32'h0);
        step;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("resv_pending", 32'(busA.rdPending[1]), 32'h1);
        checkOutput("resv_any", 32'(busA.anyPending), 32'h1);
        applyStimulus(2'b01, 5'd9, 32'h5, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("wb_pending", 32'(busA.rdPending[1]), 32'h0);
        checkOutput("wb_data", busA.rdData[1], 32'h5);
        checkOutput("wb_any_before", 32'(busA.anyPending), 32'h1);
        step;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("wb_any_after", 32'(busA.anyPending), 32'h0);
        checkOutput("wb_pending_after", 32'(busA.rdPending[1]), 32'h0);
        checkOutput("wb_data_after", busA.rdData[1], 32'h5);

        // Reserve and write x4 on the same edge.
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd4, 32'h77, 1'b1, 5'd4);
        step;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        busA.rdAddr[0] = 5'd4;
        #1;
        checkOutput("collide_data", busA.rdData[0], 32'h77);
        checkOutput("collide_pending", 32'(busA.rdPending[0]), 32'h1);
        checkOutput("collide_any", 32'(busA.anyPending), 32'h1);

        // 24-register build: address 30 does not exist, 23 is the last real one.
        busC.wrEn = 2'b11;
        busC.wrAddr[0] = 5'd30; busC.wrData[0] = 32'hDEAD;
        busC.wrAddr[1] = 5'd23; busC.wrData[1] = 32'h23;
        busC.rdAddr[0] = 5'd30; busC.rdAddr[1] = 5'd23;
        #1;
        checkOutput("range_bypass30", busC.rdData[0], 32'h0);
        checkOutput("range_bypass23", busC.rdData[1], 32'h23);
        step;
        busC.wrEn = 2'b00;
        #1;
        checkOutput("range_rd30", busC.rdData[0], 32'h0);
        checkOutput("range_pend30", 32'(busC.rdPending[0]), 32'h0);
        checkOutput("range_rd23", busC.rdData[1], 32'h23);
        checkOutput("range_any", 32'(busC.anyPending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
